// File: rtl/div.sv
// Iterative radix-2 restoring divider: DIV/DIVU/REM/REMU in 32 CALC cycles,
// with single-cycle handling of divide-by-zero and signed overflow.
package div_pkg;
    typedef logic [2:0] fu_op_t;
    localparam fu_op_t OP_DIV  = 3'd0;
    localparam fu_op_t OP_DIVU = 3'd1;
    localparam fu_op_t OP_REM  = 3'd2;
    localparam fu_op_t OP_REMU = 3'd3;
endpackage

module div
    import div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_ex_i,
    input  fu_op_t          op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            div_vld_i,
    output logic            div_rdy_o,
    output logic            div_done_o,
    output logic [XLEN-1:0] div_result_o
);

    localparam int unsigned CW = 5;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] part_q, part_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            sign1_q, sign1_d;
    logic            sign2_q, sign2_d;
    fu_op_t          op_q, op_d;
    logic [XLEN-1:0] result_q, result_d;

    // Request decode; unknown encodings fall through as unsigned quotient.
    logic            in_signed, in_rem, div_zero, ovf, accept;
    logic [XLEN-1:0] mag1, mag2;

    assign in_signed = (op_i == OP_DIV) || (op_i == OP_REM);
    assign in_rem    = (op_i == OP_REM) || (op_i == OP_REMU);
    assign div_zero  = (op2_i == '0);
    assign ovf       = in_signed && (op1_i == MIN_NEG) && (op2_i == '1);
    assign accept    = div_vld_i && (state_q == S_IDLE) && !flush_ex_i;
    assign mag1      = (in_signed && op1_i[XLEN-1]) ? -op1_i : op1_i;
    assign mag2      = (in_signed && op2_i[XLEN-1]) ? -op2_i : op2_i;

    // One restoring step; the extra top bit keeps the shifted-out remainder bit.
    logic [XLEN+1:0] trial;
    logic            step_ge;
    logic [XLEN-1:0] part_step, quo_step;
    logic            neg_quo, neg_rem, sel_rem;
    logic [XLEN-1:0] quo_fix, rem_fix, res_calc;

    assign trial     = {1'b0, part_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
    assign step_ge   = !trial[XLEN+1];
    assign part_step = step_ge ? trial[XLEN-1:0] : {part_q[XLEN-2:0], quo_q[XLEN-1]};
    assign quo_step  = {quo_q[XLEN-2:0], step_ge};

    assign neg_quo   = (op_q == OP_DIV) && (sign1_q ^ sign2_q);
    assign neg_rem   = (op_q == OP_REM) && sign1_q;
    assign sel_rem   = (op_q == OP_REM) || (op_q == OP_REMU);
    assign quo_fix   = neg_quo ? -quo_step : quo_step;
    assign rem_fix   = neg_rem ? -part_step : part_step;
    assign res_calc  = sel_rem ? rem_fix : quo_fix;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        part_d   = part_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        op_d     = op_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op_i;
                    sign1_d = op1_i[XLEN-1];
                    sign2_d = op2_i[XLEN-1];
                    cnt_d   = '0;
                    if (div_zero) begin
                        result_d = in_rem ? op1_i : '1;
                        state_d  = S_DONE;
                    end else if (ovf) begin
                        result_d = in_rem ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                    end else begin
                        part_d  = '0;
                        quo_d   = mag1;
                        dvs_d   = mag2;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                part_d = part_step;
                quo_d  = quo_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = res_calc;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Squash wins over everything in flight; the held result is untouched.
        if (flush_ex_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            part_q   <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            op_q     <= OP_DIVU;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            part_q   <= part_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    // Done is masked by a same-cycle flush so a squashed completion never pulses.
    assign div_rdy_o    = (state_q == S_IDLE);
    assign div_done_o   = (state_q == S_DONE) && !flush_ex_i;
    assign div_result_o = result_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: expected results queued at issue, popped at div_done_o.
module tb_div;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, vld;
    fu_op_t      op;
    logic [31:0] a, b;
    logic        rdy, done;
    logic [31:0] res;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    time         acc_t;

    typedef struct {
        fu_op_t      o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    div #(.XLEN(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_ex_i  (flush),
        .op_i        (op),
        .op1_i       (a),
        .op2_i       (b),
        .div_vld_i   (vld),
        .div_rdy_o   (rdy),
        .div_done_o  (done),
        .div_result_o(res)
    );

    function automatic logic [31:0] model(input fu_op_t o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (o)
            OP_DIV: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(x) / $signed(y);
            end
            OP_REM: begin
                if (y == 32'd0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(x) % $signed(y);
            end
            OP_REMU: r = (y == 32'd0) ? x : x % y;
            default: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input fu_op_t o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 1;
        if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Waits for div_rdy_o, then holds the request across exactly one accepting edge.
    task automatic issue(input fu_op_t o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        int n = 0;
        @(negedge clk);
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL issue_rdy_timeout rdy=%0b required 1", rdy);
        end
        op  = o;
        a   = x;
        b   = y;
        vld = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        acc_t = $time;
        #1 vld = 1'b0;
    endtask

    // Counts edges from the accepting edge (=1) until div_done_o is seen.
    task automatic wait_done(output bit seen, output int lat);
        seen = 1'b0;
        lat  = 1;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (rdy !== 1'b1)   begin errors++; $display("FAIL reset_rdy got %0b exp 1", rdy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (res !== 32'd0)  begin errors++; $display("FAIL reset_result got %h exp 0", res); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_basic();
        vec_t v[5];
        bit seen; int lat; logic [31:0] e;
        v[0] = '{OP_DIVU, 32'd100, 32'd7, 32'd14, 33};
        v[1] = '{OP_REMU, 32'd100, 32'd7, 32'd2, 33};
        v[2] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
        v[3] = '{OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
        v[4] = '{OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33};
        foreach (v[i]) begin
            issue(v[i].o, v[i].x, v[i].y, v[i].e);
            wait_done(seen, lat);
            e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (!seen || res !== e) begin errors++; $display("FAIL basic_result[%0d] got %h exp %h done=%0b", i, res, e, seen); end
            checks++;
            if (lat != v[i].lat) begin errors++; $display("FAIL basic_latency[%0d] got %0d exp %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_special();
        vec_t v[6];
        bit seen; int lat; logic [31:0] e;
        v[0] = '{OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1};
        v[1] = '{OP_REMU, 32'd5, 32'd0, 32'd5, 1};
        v[2] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        v[3] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
        v[4] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33};
        v[5] = '{3'd6,    32'd77, 32'd0, 32'hFFFF_FFFF, 1};
        foreach (v[i]) begin
            issue(v[i].o, v[i].x, v[i].y, v[i].e);
            wait_done(seen, lat);
            e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (!seen || res !== e) begin errors++; $display("FAIL special_result[%0d] got %h exp %h done=%0b", i, res, e, seen); end
            checks++;
            if (lat != v[i].lat) begin errors++; $display("FAIL special_latency[%0d] got %0d exp %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_flush_calc();
        bit seen; int lat; bit saw_done = 1'b0; logic [31:0] e;
        issue(OP_DIVU, 32'd1000, 32'd7, 32'd142);
        void'(exp_q.pop_back());
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL flush_idle rdy got %0b exp 1", rdy); end
        repeat (40) begin
            @(posedge clk);
            #1 if (done) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL flush_no_done got done pulse exp none"); end
        checks++; if (res !== last_exp) begin errors++; $display("FAIL flush_result_held got %h exp %h", res, last_exp); end
        issue(OP_DIVU, 32'd9, 32'd3, 32'd3);
        wait_done(seen, lat);
        e = exp_q.pop_front();
        last_exp = e;
        checks++; if (!seen || res !== e) begin errors++; $display("FAIL flush_next_result got %h exp %h", res, e); end
    endtask

    task automatic test_flush_done();
        issue(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        void'(exp_q.pop_front());
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL flushdone_pre got %0b exp 1", done); end
        flush = 1'b1;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flushdone_suppress got %0b exp 0", done); end
        @(posedge clk);
        #1 flush = 1'b0;
        checks++; if (rdy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL flushdone_idle rdy=%0b done=%0b exp 1/0", rdy, done); end
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        op = OP_DIVU; a = 32'd10; b = 32'd2; vld = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rdy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept[%0d] rdy=%0b done=%0b exp 1/0", i, rdy, done); end
        end
        vld = 1'b0; flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit seen; int lat; time t0; logic [31:0] e;
        issue(OP_DIVU, 32'd50, 32'd5, 32'd10);
        t0 = acc_t;
        wait_done(seen, lat);
        e = exp_q.pop_front();
        checks++; if (!seen || res !== e) begin errors++; $display("FAIL b2b_first got %h exp %h", res, e); end
        issue(OP_REMU, 32'd50, 32'd7, 32'd1);
        checks++; if (acc_t - t0 != 340) begin errors++; $display("FAIL b2b_spacing got %0t exp 340", acc_t - t0); end
        wait_done(seen, lat);
        e = exp_q.pop_front();
        last_exp = e;
        checks++; if (!seen || res !== e) begin errors++; $display("FAIL b2b_second got %h exp %h", res, e); end
    endtask

    task automatic test_async_reset();
        bit seen; int lat; bit saw_done = 1'b0; logic [31:0] e;
        issue(OP_DIVU, 32'd1000, 32'd3, 32'd333);
        void'(exp_q.pop_front());
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (rdy !== 1'b1)  begin errors++; $display("FAIL arst_rdy got %0b exp 1", rdy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got %0b exp 0", done); end
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL arst_result got %h exp 0", res); end
        op = OP_DIVU; a = 32'd9; b = 32'd3; vld = 1'b1;
        exp_q.push_back(32'd3);
        repeat (3) begin
            @(posedge clk);
            #1 if (done || !rdy) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL arst_hold got activity exp idle"); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 vld = 1'b0;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL arst_first_accept rdy=%0b exp 0", rdy); end
        wait_done(seen, lat);
        e = exp_q.pop_front();
        last_exp = e;
        checks++; if (!seen || res !== e) begin errors++; $display("FAIL arst_result_after got %h exp %h", res, e); end
        checks++; if (lat != 33) begin errors++; $display("FAIL arst_latency got %0d exp 33", lat); end
    endtask

    task automatic test_random();
        bit seen; int lat; logic [31:0] e; fu_op_t o; logic [31:0] x, y; int el;
        for (int i = 0; i < 12; i++) begin
            o = fu_op_t'($urandom_range(0, 7));
            x = $urandom();
            case ($urandom_range(0, 4))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'($urandom_range(1, 20));
                default: y = $urandom();
            endcase
            if (i == 0) begin o = OP_DIV; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (i == 1) begin o = OP_DIVU; x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; end
            el = model_lat(o, x, y);
            issue(o, x, y, model(o, x, y));
            wait_done(seen, lat);
            e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (!seen || res !== e) begin errors++; $display("FAIL rand_result[%0d] op=%0d %h/%h got %h exp %h", i, o, x, y, res, e); end
            checks++;
            if (lat != el) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, lat, el); end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; vld = 1'b0; op = OP_DIVU; a = '0; b = '0;
        last_exp = '0;
        test_reset();
        test_basic();
        test_special();
        test_flush_calc();
        test_flush_done();
        test_flush_idle();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits; only 32 is required to be supported.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_i  input  1  reset, asynchronous assert, active-high.
REQ-004 flush_ex_i  input  1  squashes the in-flight or offered operation.
REQ-005 op_i  input  fu_op_t  operation: DIV, DIVU, REM or REMU; any other encoding is treated as DIVU.
REQ-006 op1_i  input  XLEN  dividend.
REQ-007 op2_i  input  XLEN  divisor.
REQ-008 div_vld_i  input  1  request valid; op_i, op1_i and op2_i are sampled on the accepting edge.
REQ-009 div_rdy_o  output  1  block can accept a request (high only in IDLE).
REQ-010 div_done_o  output  1  single-cycle pulse; div_result_o is valid while it is high.
REQ-011 div_result_o  output  XLEN  registered result, held until the next completion.

Function
REQ-012 The block SHALL have three states: IDLE, CALC and DONE.
REQ-013 A request SHALL be accepted on an edge where div_vld_i=1, div_rdy_o=1 and flush_ex_i=0.
REQ-014 On acceptance of a special case, the block SHALL go IDLE->DONE:
- divisor zero, or
- DIV/REM with op1_i=0x80000000 and op2_i=0xFFFFFFFF.
REQ-015 On acceptance of any other request, the block SHALL load the operands and go IDLE->CALC:
- load the dividend and divisor magnitudes; magnitude = absolute value for DIV/REM, raw value for DIVU/REMU;
- latch both operand signs and op_i;
- clear a 5-bit iteration counter.
REQ-016 CALC SHALL perform one restoring radix-2 step per cycle:
- shift the {remainder, quotient} register left by 1;
- trial-subtract the divisor magnitude from the remainder using XLEN+1-bit arithmetic;
- on a non-negative difference, keep the difference and set quotient bit 0 to 1.
REQ-017 CALC SHALL last exactly 32 cycles; the counter increments each cycle, and counter=31 transitions CALC->DONE.
REQ-018 Sign correction SHALL be applied when entering DONE:
- DIV: quotient negated when the operand signs differ;
- REM: remainder negated when the dividend is negative;
- DIVU/REMU: no correction.
REQ-019 div_result_o SHALL be the quotient for DIV/DIVU and the remainder for REM/REMU, registered on the edge that enters DONE.
REQ-020 Divide-by-zero results SHALL be:
- DIV/DIVU: 0xFFFFFFFF;
- REM/REMU: op1_i unchanged.
REQ-021 Overflow results SHALL be:
- DIV: 0x80000000;
- REM: 0x00000000.
REQ-022 DONE SHALL last exactly one cycle, with div_done_o=1, then go DONE->IDLE unconditionally.
REQ-023 Latency SHALL be 33 edges from the accepting edge to div_done_o high for normal operations, and 1 edge for special cases.
REQ-024 div_rdy_o SHALL be combinational from state only and SHALL NOT depend on div_vld_i.
REQ-025 A request presented while not in IDLE SHALL be ignored; the requester holds div_vld_i until it sees div_rdy_o.
REQ-026 flush_ex_i=1 in CALC or DONE SHALL force IDLE on the next edge:
- div_done_o is 0 in the flushed DONE cycle (suppressed);
- div_result_o keeps its prior value.
REQ-027 flush_ex_i=1 together with div_vld_i=1 in IDLE SHALL block acceptance; flush has priority.
REQ-028 A new request SHALL be acceptable in the cycle immediately after DONE, giving back-to-back throughput of one operation per 34 cycles.

Reset
REQ-029 While rst_i=1, regardless of clk_i, the block SHALL hold:
- state=IDLE;
- counter=0;
- div_result_o=0;
- div_done_o=0;
- div_rdy_o=1.
REQ-030 A reset asserted mid-CALC SHALL abandon the operation with no div_done_o pulse.
REQ-031 After reset deasserts, the block SHALL accept a request on the first rising edge.

Verification
REQ-032 DIVU 100/7 -> div_done_o high exactly 33 edges after acceptance, result 14; REMU 100/7 -> result 2.
REQ-033 DIV of 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFD (-3); REM of the same -> 0xFFFFFFFF (-1); REM of 7 by 0xFFFFFFFE (-2) -> 1.
REQ-034 Divide by zero:
- DIV 5/0 -> 0xFFFFFFFF, one edge after acceptance;
- REMU 5/0 -> 5.
REQ-035 Overflow, DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 edge; REM of the same -> 0.
REQ-036 flush_ex_i pulsed at CALC cycle 10 ->
- IDLE next edge;
- no div_done_o;
- div_result_o unchanged;
- the next request (DIVU 9/3) returns 3.
REQ-037 rst_i asserted mid-CALC and off a clock edge -> outputs reach reset values immediately; div_vld_i held high through reset -> accepted on the first edge after deassertion.
